bcd_core: RTL and testbench

- Sequential binary-to-BCD conversion datapath, placed directly downstream of the BCD register/config block.
- Consumes the `reverse_order` and `delay` configuration outputs of that block.
- Converts one `data_WIDTH`-bit unsigned word per transaction using shift-and-add-3 (double dabble).
- Presents packed BCD digits on a valid/ready output and keeps a completed-conversion count for the status register.

---
 rtl/bcd_pkg.sv | 20 ++
 rtl/bcd_if.sv | 27 ++
 rtl/bcd_dabble_step.sv | 28 ++
 rtl/bcd_core.sv | 120 ++++++++++++
 tb/tb_bcd_core.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
// Imported by the interface, the dabble step and the core.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        WAIT,
        DONE
    } state_t;

    localparam int DELAY_W = 5;

    // Decimal digits needed for a w-bit unsigned value: ceil(w*log10(2)).
    // 2^w is never a power of ten, so the ceiling never lands on an integer.
    function automatic int min_digits(input int w);
        return (w * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bcd_if.sv
// Input and output valid/ready channels of the BCD converter.
// The producer/consumer side is master; the converter is slave.
interface bcd_if
    import bcd_pkg::*;
#(
    parameter int data_WIDTH = 8,
    parameter int DIGITS     = 3
);

    logic                  in_valid;
    logic                  in_ready;
    logic [data_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_bcd;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_bcd
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_bcd
    );

endinterface

// File: rtl/bcd_dabble_step.sv
// One shift-and-add-3 step: correct every digit >= 5, then shift
// the {digits, binary} pair left by one bit.
module bcd_dabble_step
    import bcd_pkg::*;
#(
    parameter int W      = 8,
    parameter int DIGITS = 3
) (
    input  logic [4*DIGITS-1:0] dig_i,
    input  logic [W-1:0]        bin_i,
    output logic [4*DIGITS-1:0] dig_o,
    output logic [W-1:0]        bin_o
);

    logic [4*DIGITS-1:0] adj;

    always_comb begin
        adj = dig_i;
        for (int i = 0; i < DIGITS; i++) begin
            if (adj[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
    end

    assign dig_o = {adj[4*DIGITS-2:0], bin_i[W-1]};
    assign bin_o = bin_i << 1;

endmodule

// File: rtl/bcd_core.sv
// Sequential double-dabble converter with optional post-delay and
// digit reversal; counts completed output handshakes.
module bcd_core
    import bcd_pkg::*;
#(
    parameter int data_WIDTH = 8,
    parameter int DIGITS     = 3,
    parameter int DELAY_W    = bcd_pkg::DELAY_W
) (
    input  logic               clk,
    input  logic               rst,
    bcd_if.slave               bus,
    input  logic               reverse_order,
    input  logic [DELAY_W-1:0] delay,
    output logic               busy,
    output logic [7:0]         conv_count
);

    localparam int SW = $clog2(data_WIDTH + 1);
    localparam logic [SW-1:0] LAST = SW'(data_WIDTH - 1);

    if (DIGITS < min_digits(data_WIDTH)) begin : g_digits_chk
        $error("bcd_core: DIGITS too small for data_WIDTH");
    end

    state_t                state_q, state_d;
    logic [data_WIDTH-1:0] bin_q;
    logic [4*DIGITS-1:0]   dig_q;
    logic [SW-1:0]         step_q;
    logic [DELAY_W-1:0]    timer_q;
    logic [DELAY_W-1:0]    dly_q;
    logic                  rev_q;
    logic [4*DIGITS-1:0]   out_q;
    logic [7:0]            cnt_q;

    logic [4*DIGITS-1:0]   step_dig;
    logic [data_WIDTH-1:0] step_bin;
    logic [4*DIGITS-1:0]   src;
    logic [4*DIGITS-1:0]   rev_dig;
    logic [4*DIGITS-1:0]   result;
    logic                  accept;
    logic                  last_step;

    bcd_dabble_step #(
        .W      (data_WIDTH),
        .DIGITS (DIGITS)
    ) u_step (
        .dig_i (dig_q),
        .bin_i (bin_q),
        .dig_o (step_dig),
        .bin_o (step_bin)
    );

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        last_step = 1'b0;
        unique case (state_q)
            IDLE: if (bus.in_valid) begin
                accept  = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: if (step_q == LAST) begin
                last_step = 1'b1;
                state_d   = (dly_q == '0) ? DONE : WAIT;
            end
            WAIT: if (timer_q == DELAY_W'(1)) state_d = DONE;
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Result is captured on DONE entry: from the final step or from dig_q after WAIT.
    always_comb begin
        src     = (state_q == SHIFT) ? step_dig : dig_q;
        rev_dig = '0;
        for (int i = 0; i < DIGITS; i++)
            rev_dig[4*i +: 4] = src[4*(DIGITS-1-i) +: 4];
        result = rev_q ? rev_dig : src;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            dig_q   <= '0;
            step_q  <= '0;
            timer_q <= '0;
            dly_q   <= '0;
            rev_q   <= 1'b0;
            out_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                bin_q  <= bus.in_data;
                rev_q  <= reverse_order;
                dly_q  <= delay;
                dig_q  <= '0;
                step_q <= '0;
            end
            if (state_q == SHIFT) begin
                bin_q  <= step_bin;
                dig_q  <= step_dig;
                step_q <= step_q + 1'b1;
                if (last_step) timer_q <= dly_q;
            end
            if (state_q == WAIT) timer_q <= timer_q - 1'b1;
            if (state_d == DONE && state_q != DONE) out_q <= result;
            if (state_q == DONE && bus.out_ready) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_bcd   = out_q;
    assign busy          = (state_q != IDLE);
    assign conv_count    = cnt_q;

endmodule

// File: tb/tb_bcd_core.sv
// Scoreboard bench for bcd_core: directed vectors plus a full
// 0..255 sweep with random output backpressure.
module tb_bcd_core;
    import bcd_pkg::*;

    localparam int W = 8;
    localparam int D = 3;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               reverse_order = 1'b0;
    logic [DELAY_W-1:0] delay = '0;
    logic               busy;
    logic [7:0]         conv_count;

    bcd_if #(.data_WIDTH(W), .DIGITS(D)) bus ();

    bcd_core #(
        .data_WIDTH (W),
        .DIGITS     (D),
        .DELAY_W    (DELAY_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .reverse_order (reverse_order),
        .delay         (delay),
        .busy          (busy),
        .conv_count    (conv_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [11:0] bcd;
        int          e0;
        int          lat;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    bit   seen = 1'b0;
    bit   sweep_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] ref_bcd(input int v, input bit rev);
        logic [3:0] d0, d1, d2;
        d0 = 4'(v % 10);
        d1 = 4'((v / 10) % 10);
        d2 = 4'(v / 100);
        return rev ? {d0, d1, d2} : {d2, d1, d0};
    endfunction

    // Monitor: checks latency on first DONE cycle, value every DONE cycle.
    always @(negedge clk) begin
        if (rst) begin
            seen = 1'b0;
        end else if (bus.out_valid) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out: got %0h expected none",
                         bus.out_bcd);
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    if (q[0].lat >= 0)
                        chk("latency", cyc - q[0].e0, q[0].lat);
                end
                chk("out_bcd", bus.out_bcd, q[0].bcd);
                if (bus.out_ready) begin
                    void'(q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic send(input int v, input bit rev, input int dly,
                        input bit push, input logic [11:0] exp_bcd,
                        input int lat);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b1;
        bus.in_data   = W'(v);
        reverse_order = rev;
        delay         = DELAY_W'(dly);
        @(negedge clk);
        while (!bus.in_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got busy expected ready v=%0d", v);
        end else if (push) begin
            q.push_back('{exp_bcd, cyc + 1, lat});
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 2000) begin
            n++;
            @(negedge clk);
        end
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0",
                     q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_bcd", bus.out_bcd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", conv_count, 0);

        send(123, 0, 0, 1, 12'h123, 8);
        drain();
        chk("held_one_cycle", bus.out_valid, 0);
        chk("bcd_kept", bus.out_bcd, 12'h123);
        chk("count_1", conv_count, 1);

        // Abort 200 mid-conversion; nothing may come out for it.
        send(200, 0, 0, 0, 12'h000, 0);
        repeat (2) @(negedge clk);
        chk("abort_busy", busy, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", bus.in_ready, 1);
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_out_bcd", bus.out_bcd, 0);
        chk("abort_count", conv_count, 0);
        repeat (20) @(negedge clk);

        send(255, 1, 3, 1, 12'h552, 11);
        drain();
        send(7, 1, 0, 1, 12'h700, 8);
        drain();

        bus.out_ready = 1'b0;
        send(99, 0, 0, 1, 12'h099, 8);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd42;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            n++;
            @(negedge clk);
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_in_ready", bus.in_ready, 0);
            if (i < 4) @(negedge clk);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        send(42, 0, 0, 1, 12'h042, 8);
        drain();

        send(58, 0, 0, 1, 12'h058, 8);
        reverse_order = 1'b1;
        delay         = 5'd31;
        drain();
        reverse_order = 1'b0;
        delay         = '0;
        chk("count_5", conv_count, 5);

        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;

        fork
            begin
                for (int v = 0; v < 256; v++) begin
                    send(v, (v % 3) == 0, v % 4, 1,
                         ref_bcd(v, (v % 3) == 0), 8 + (v % 4));
                end
                drain();
                sweep_done = 1'b1;
            end
            begin
                while (!sweep_done) begin
                    @(posedge clk);
                    #1 bus.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("count_wrap", conv_count, 0);
        chk("sweep_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
